cond_code_unit: RTL and testbench
=================================

COND_CODE_UNIT -- requirements
Module: cond_code_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, bus width evaluated for condition codes (legal range 2..32).
REQ-002 SHALL provide parameter DEPTH, default 4, number of entries in the condition-code save stack (legal range 1..16).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port BUS  input  WIDTH  datapath bus value to classify, or PSR image when ldPSR.
REQ-006 SHALL provide port IR  input  16  instruction register; IR[11:9] is the branch n/z/p mask.
REQ-007 SHALL provide port ldCC  input  1  load condition codes from classified BUS.
REQ-008 SHALL provide port ldPSR  input  1  load condition codes from BUS[2:0] = {N,Z,P}.
REQ-009 SHALL provide port ldBEN  input  1  load branch-enable register.
REQ-010 SHALL provide port push  input  1  save current {N,Z,P} on stack (interrupt entry).
REQ-011 SHALL provide port pop  input  1  restore {N,Z,P} from stack (RTI).
REQ-012 SHALL provide ports NVal, ZVal, PVal  output  1 each  registered condition codes.
REQ-013 SHALL provide port BEN  output  1  registered branch enable.
REQ-014 SHALL provide port depth  output  5  number of valid stack entries, 0..DEPTH.
REQ-015 SHALL provide ports full, empty  output  1 each  depth==DEPTH, depth==0 (combinational from depth).
REQ-016 SHALL provide port err  output  1  sticky misuse flag.

Function
REQ-017 Classification SHALL be combinational: BUS[WIDTH-1]=1 -> {1,0,0}; BUS all zero -> {0,1,0}; otherwise {0,0,1}.
REQ-018 Update priority per falling edge SHALL be: rst > successful pop > ldPSR > ldCC > hold.
REQ-019 Successful pop (pop=1, push=0, depth>0): {N,Z,P} <= top entry; depth decrements by 1.
REQ-020 Successful push (push=1, pop=0, depth<DEPTH): top entry <= {N,Z,P} values held before this edge; depth increments by 1; CC update on the same edge still follows REQ-018.
REQ-021 ldPSR with one-hot BUS[2:0]: {N,Z,P} <= BUS[2:0]; non-one-hot value: {N,Z,P} <= {0,1,0} and err <= 1.
REQ-022 ldCC: {N,Z,P} <= classification of BUS (REQ-017), 0-cycle latency to next edge.
REQ-023 ldBEN: BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) using the condition codes held before this edge; BEN otherwise holds.
REQ-024 Push when full: stack and depth unchanged, err <= 1; other loads proceed normally.
REQ-025 Pop when empty: stack, depth unchanged, CC not changed by pop, err <= 1; ldPSR/ldCC on that edge proceed normally.
REQ-026 push and pop both 1: neither takes effect, err <= 1; ldPSR/ldCC proceed normally.
REQ-027 err SHALL remain 1 until rst; {N,Z,P} SHALL be exactly one-hot at every edge after reset.
REQ-028 Stack storage SHALL be LIFO; entries above depth are don't-care and never observable.

Reset
REQ-029 On rst=1 at a falling edge: NVal=0, ZVal=1, PVal=0, BEN=0, depth=0, err=0, all other inputs ignored.
REQ-030 rst asserted mid-sequence (stack non-empty) SHALL discard all saved entries; empty=1 after the edge.
REQ-031 Outputs before the first reset edge are undefined; the bench SHALL apply rst for at least one edge.

Verification
REQ-032 Classify: WIDTH=16, ldCC with BUS=16'h8000, then 16'h0000, then 16'h0001 -> NZP = 100, 010, 001 after successive edges.
REQ-033 Branch: NZP=001, IR[11:9]=3'b011, ldBEN and ldCC(BUS=16'hFFFF) same edge -> BEN=1, NZP=100 (BEN uses old CC).
REQ-034 Stack: DEPTH=4, NZP=100 push, ldCC(BUS=0) same edge, then pop -> after push NZP=010 depth=1; after pop NZP=100 depth=0 empty=1.
REQ-035 Overflow: 5 pushes with DEPTH=4 -> depth=4 full=1, err=1 after 5th edge; 4 pops restore saved values in reverse order.
REQ-036 Misuse: ldPSR with BUS[2:0]=3'b110 -> NZP=010, err=1; pop on empty with ldCC(BUS=16'h0005) -> NZP=001, depth=0, err stays 1 until rst.
REQ-037 Reset mid-operation: depth=3, err=1, rst one edge -> NZP=010, BEN=0, depth=0, empty=1, err=0.

Source files
------------

// File: rtl/cond_code_unit.sv
// cond_code_unit
//   Condition-code unit: classifies a datapath bus into one-hot {N,Z,P}, holds
//   the registered condition codes, computes the branch-enable flag and keeps a
//   small LIFO of saved condition codes for interrupt entry / RTI.
//   All state changes on the falling edge of clk.
//
// Ports
//   clk            single clock (state updates on falling edge)
//   rst            synchronous active-high reset
//   BUS[WIDTH-1:0] value to classify (ldCC) or PSR image in BUS[2:0] (ldPSR)
//   IR[15:0]       instruction register, IR[11:9] = branch n/z/p mask
//   ldCC           load CC from classified BUS
//   ldPSR          load CC from BUS[2:0] = {N,Z,P}
//   ldBEN          load branch-enable register
//   push / pop     save / restore {N,Z,P} on the stack
//   NVal/ZVal/PVal registered condition codes
//   BEN            registered branch enable
//   depth[4:0]     valid stack entries, full / empty decoded from it
//   err            sticky misuse flag, cleared only by rst
module cond_code_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] BUS,
   input  logic [15:0]      IR,
   input  logic             ldCC,
   input  logic             ldPSR,
   input  logic             ldBEN,
   input  logic             push,
   input  logic             pop,
   output logic             NVal,
   output logic             ZVal,
   output logic             PVal,
   output logic             BEN,
   output logic [4:0]       depth,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic [2:0] classify(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1])
         return 3'b100;
      else if (v == '0)
         return 3'b010;
      else
         return 3'b001;
   endfunction

   function automatic logic is_onehot(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   logic [2:0]    nzp_p0;
   logic [2:0]    nzp_d;
   logic [2:0]    psr_img;
   logic [2:0]    stack [DEPTH];
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          do_push;
   logic          do_pop;
   logic          psr_bad;
   logic          misuse;
   logic          unused_ir;

   // Only the branch mask of IR is meaningful here.
   assign unused_ir = ^{IR[15:12], IR[8:0]};

   assign full    = (depth == 5'(DEPTH));
   assign empty   = (depth == 5'd0);
   assign psr_img = 3'(BUS);
   assign wr_idx  = AW'(depth);
   assign rd_idx  = AW'(depth - 5'd1);

   // Simultaneous push and pop cancel each other out and count as misuse.
   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;

   // A bad PSR image only matters when ldPSR actually wins the CC update.
   assign psr_bad = ldPSR & ~do_pop & ~is_onehot(psr_img);
   assign misuse  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty) | psr_bad;

   always_comb begin
      nzp_d = nzp_p0;
      if (do_pop)
         nzp_d = stack[rd_idx];
      else if (ldPSR)
         nzp_d = is_onehot(psr_img) ? psr_img : 3'b010;
      else if (ldCC)
         nzp_d = classify(BUS);
   end

   // Control / condition-code state
   always_ff @(negedge clk) begin
      if (rst) begin
         nzp_p0 <= 3'b010;
         BEN    <= 1'b0;
         depth  <= 5'd0;
         err    <= 1'b0;
      end else begin
         nzp_p0 <= nzp_d;
         if (ldBEN)
            BEN <= |(IR[11:9] & nzp_p0);
         if (do_push)
            depth <= depth + 5'd1;
         else if (do_pop)
            depth <= depth - 5'd1;
         if (misuse)
            err <= 1'b1;
      end
   end

   // Stack storage: entries at or above depth are never read, so no reset.
   always_ff @(negedge clk) begin
      if (do_push)
         stack[wr_idx] <= nzp_p0;
   end

   assign {NVal, ZVal, PVal} = nzp_p0;

endmodule

// File: tb/tb_cond_code_unit.sv
module tb_cond_code_unit;

   typedef struct {
      logic        rst;
      logic [15:0] bus;
      logic [2:0]  irm;
      logic        ldcc;
      logic        ldpsr;
      logic        ldben;
      logic        push;
      logic        pop;
      logic [2:0]  nzp;
      logic        ben;
      logic [4:0]  dep;
      logic        err;
      string       tag;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] BUS;
   logic [15:0] IR;
   logic        ldCC, ldPSR, ldBEN, push, pop;
   logic        NVal, ZVal, PVal, BEN;
   logic [4:0]  depth;
   logic        full, empty, err;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   vec_t exp_q[$];

   cond_code_unit #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .BUS(BUS), .IR(IR),
      .ldCC(ldCC), .ldPSR(ldPSR), .ldBEN(ldBEN), .push(push), .pop(pop),
      .NVal(NVal), .ZVal(ZVal), .PVal(PVal), .BEN(BEN),
      .depth(depth), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(string tag, logic r, logic [15:0] b, logic [2:0] m,
                               logic lc, logic lp, logic lb, logic pu, logic po,
                               logic [2:0] n, logic be, logic [4:0] d, logic e);
      vec_t v;
      v.tag = tag; v.rst = r; v.bus = b; v.irm = m;
      v.ldcc = lc; v.ldpsr = lp; v.ldben = lb; v.push = pu; v.pop = po;
      v.nzp = n; v.ben = be; v.dep = d; v.err = e;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one vector just after a rising edge, let the falling edge update
   // the DUT, then compare on the following rising edge.
   task automatic apply(input vec_t v);
      vec_t e;
      #1;
      rst   = v.rst;
      BUS   = v.bus;
      IR    = {4'hA, v.irm, 9'h155};
      ldCC  = v.ldcc;
      ldPSR = v.ldpsr;
      ldBEN = v.ldben;
      push  = v.push;
      pop   = v.pop;
      exp_q.push_back(v);
      @(negedge clk);
      @(posedge clk);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, "_nzp"},   32'({NVal, ZVal, PVal}), 32'(e.nzp));
         check({e.tag, "_ben"},   32'(BEN),   32'(e.ben));
         check({e.tag, "_depth"}, 32'(depth), 32'(e.dep));
         check({e.tag, "_full"},  32'(full),  32'(e.dep == 5'd4));
         check({e.tag, "_empty"}, 32'(empty), 32'(e.dep == 5'd0));
         check({e.tag, "_err"},   32'(err),   32'(e.err));
      end
   endtask

   initial begin
      rst = 1'b1; BUS = '0; IR = '0;
      ldCC = 0; ldPSR = 0; ldBEN = 0; push = 0; pop = 0;

      //            tag        rst bus      irm    lc lp lb pu po  nzp    ben dep err
      vecs.push_back(mk("reset0",   1, 16'h1234, 3'b111, 1, 1, 1, 1, 0, 3'b010, 0, 0, 0));
      vecs.push_back(mk("cls_neg",  0, 16'h8000, 3'b000, 1, 0, 0, 0, 0, 3'b100, 0, 0, 0));
      vecs.push_back(mk("cls_zero", 0, 16'h0000, 3'b000, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0));
      vecs.push_back(mk("cls_pos",  0, 16'h0001, 3'b000, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0));
      vecs.push_back(mk("ben_old",  0, 16'hFFFF, 3'b011, 1, 0, 1, 0, 0, 3'b100, 1, 0, 0));
      vecs.push_back(mk("hold",     0, 16'h0000, 3'b111, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0));
      vecs.push_back(mk("ben_miss", 0, 16'h0000, 3'b010, 0, 0, 1, 0, 0, 3'b100, 0, 0, 0));
      vecs.push_back(mk("push_cc",  0, 16'h0000, 3'b000, 1, 0, 0, 1, 0, 3'b010, 0, 1, 0));
      vecs.push_back(mk("pop_cc",   0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0));
      vecs.push_back(mk("push1",    0, 16'h0001, 3'b000, 1, 0, 0, 1, 0, 3'b001, 0, 1, 0));
      vecs.push_back(mk("push2",    0, 16'h0000, 3'b000, 1, 0, 0, 1, 0, 3'b010, 0, 2, 0));
      vecs.push_back(mk("push3",    0, 16'h8000, 3'b000, 1, 0, 0, 1, 0, 3'b100, 0, 3, 0));
      vecs.push_back(mk("push4",    0, 16'h0001, 3'b000, 1, 0, 0, 1, 0, 3'b001, 0, 4, 0));
      vecs.push_back(mk("push_ovf", 0, 16'h0000, 3'b000, 1, 0, 0, 1, 0, 3'b010, 0, 4, 1));
      vecs.push_back(mk("pop4",     0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b100, 0, 3, 1));
      vecs.push_back(mk("pop3",     0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b010, 0, 2, 1));
      vecs.push_back(mk("pop2",     0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b001, 0, 1, 1));
      vecs.push_back(mk("pop1",     0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b100, 0, 0, 1));
      vecs.push_back(mk("reset1",   1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0));
      vecs.push_back(mk("psr_bad",  0, 16'h0006, 3'b000, 0, 1, 0, 0, 0, 3'b010, 0, 0, 1));
      vecs.push_back(mk("psr_n",    0, 16'hFFFC, 3'b000, 0, 1, 0, 0, 0, 3'b100, 0, 0, 1));
      vecs.push_back(mk("psr_pri",  0, 16'h8001, 3'b000, 1, 1, 0, 0, 0, 3'b001, 0, 0, 1));
      vecs.push_back(mk("pop_emp",  0, 16'h0005, 3'b000, 1, 0, 0, 0, 1, 3'b001, 0, 0, 1));
      vecs.push_back(mk("pushpop",  0, 16'h8000, 3'b000, 1, 0, 0, 1, 1, 3'b100, 0, 0, 1));

      @(posedge clk);
      foreach (vecs[i]) apply(vecs[i]);

      // Hand-written sequence: build a non-empty stack with err set, check
      // pop-over-ldPSR priority, then reset mid-operation.
      apply(mk("r2",        1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0));
      apply(mk("s_push1",   0, 16'h0000, 3'b000, 0, 0, 0, 1, 0, 3'b010, 0, 1, 0));
      apply(mk("s_push2",   0, 16'h0001, 3'b000, 0, 1, 0, 1, 0, 3'b001, 0, 2, 0));
      apply(mk("s_push3",   0, 16'h0000, 3'b001, 0, 0, 1, 1, 0, 3'b001, 1, 3, 0));
      apply(mk("s_pop_pri", 0, 16'h0004, 3'b000, 0, 1, 0, 0, 1, 3'b001, 1, 2, 0));
      apply(mk("s_push3b",  0, 16'h0000, 3'b000, 0, 0, 0, 1, 0, 3'b001, 1, 3, 0));
      apply(mk("s_both",    0, 16'h0000, 3'b000, 0, 0, 0, 1, 1, 3'b001, 1, 3, 1));
      apply(mk("s_rst",     1, 16'h8000, 3'b111, 1, 0, 1, 1, 0, 3'b010, 0, 0, 0));
      apply(mk("s_pop_emp", 0, 16'h0000, 3'b000, 0, 0, 0, 0, 1, 3'b010, 0, 0, 1));

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
